// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor arbiter: data width, opcode
// encodings understood by the arithmetic coprocessor, and FSM states.
package coproc_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_MUL = 2'd2;
  localparam logic [OP_W-1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/coproc_arbiter_rr.sv
// Combinational round-robin picker: starting one slot above the previous
// winner and wrapping, selects the first active request.
module rr_arbiter
  import coproc_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand_idx;

  // Scan upward from last_grant+1 modulo NUM_REQ; the first active slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_grant && req[cand_idx]) begin
        any_grant       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/coproc_arbiter.sv
// Shares one arithmetic coprocessor among NUM_REQ requesters. Requests are
// granted round-robin, one operation is in flight at a time, and the result
// (or a timeout error) is returned on the winner's response channel.
module coproc_arbiter
  import coproc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [32*NUM_REQ-1:0]      req_num1,
  input  logic [32*NUM_REQ-1:0]      req_num2,
  input  logic [2*NUM_REQ-1:0]       req_instr,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [31:0]                rsp_result,
  output logic                       rsp_error,
  output logic [31:0]                cp_num1,
  output logic [31:0]                cp_num2,
  output logic [1:0]                 cp_instruction,
  output logic                       cp_start,
  input  logic [31:0]                cp_result,
  input  logic                       cp_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]  last_grant;
  logic [CNT_W-1:0]  wait_cnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               rsp_fire;
  logic               wait_expired;

  logic [DATA_W-1:0]  num1_slot  [NUM_REQ];
  logic [DATA_W-1:0]  num2_slot  [NUM_REQ];
  logic [OP_W-1:0]    instr_slot [NUM_REQ];

  // Unpack the per-requester operand buses so the winner can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign num1_slot[gi]  = req_num1[gi*DATA_W +: DATA_W];
    assign num2_slot[gi]  = req_num2[gi*DATA_W +: DATA_W];
    assign instr_slot[gi] = req_instr[gi*OP_W +: OP_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_grant  (arb_any)
  );

  // Other requesters' rsp_ready bits are deliberately ignored.
  assign rsp_fire     = (state == ST_RESP) && rsp_ready[grant_id];
  assign wait_expired = (wait_cnt == CNT_LAST);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    cp_start  = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        req_ready = arb_grant;
        if (arb_any) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cp_start  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cp_ready || wait_expired) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[grant_id] = 1'b1;
        if (rsp_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, wait counter, result/error capture and grant bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant     <= IDX_W'(NUM_REQ - 1);
      grant_id       <= '0;
      cp_num1        <= '0;
      cp_num2        <= '0;
      cp_instruction <= '0;
      rsp_result     <= '0;
      rsp_error      <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            cp_num1        <= num1_slot[arb_idx];
            cp_num2        <= num2_slot[arb_idx];
            cp_instruction <= instr_slot[arb_idx];
            grant_id       <= arb_idx;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (cp_ready) begin
            rsp_result <= cp_result;
            rsp_error  <= 1'b0;
          end else if (wait_expired) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            last_grant <= grant_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_arbiter.sv
// Bench for coproc_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_coproc_arbiter;
  import coproc_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;
  localparam int IW = $clog2(NR);

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [32*NR-1:0]  req_num1;
  logic [32*NR-1:0]  req_num2;
  logic [2*NR-1:0]   req_instr;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_error;
  logic [31:0]       cp_num1;
  logic [31:0]       cp_num2;
  logic [1:0]        cp_instruction;
  logic              cp_start;
  logic [31:0]       cp_result;
  logic              cp_ready;
  logic              busy;
  logic [IW-1:0]     grant_id;

  logic [31:0] op1 [NR];
  logic [31:0] op2 [NR];
  logic [1:0]  opc [NR];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_num1[gi*32 +: 32] = op1[gi];
    assign req_num2[gi*32 +: 32] = op2[gi];
    assign req_instr[gi*2 +: 2]  = opc[gi];
  end

  coproc_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_num1       (req_num1),
    .req_num2       (req_num2),
    .req_instr      (req_instr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_error      (rsp_error),
    .cp_num1        (cp_num1),
    .cp_num2        (cp_num2),
    .cp_instruction (cp_instruction),
    .cp_start       (cp_start),
    .cp_result      (cp_result),
    .cp_ready       (cp_ready),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction-level model state
  int          mdl_last;
  bit          op_open;
  int          exp_g;
  logic [31:0] exp_res;
  bit          exp_err;
  int          t_acc;
  int          lat_cur;
  int          cfg_lat;
  bit          acc_flag;
  bit          done_flag;
  int          grant_log [$];
  int          pulse_at;
  bit          spur_issue;
  bit          hold [NR];
  logic [31:0] acc_op1;
  logic [31:0] acc_op2;
  logic [1:0]  acc_opc;
  int          hs_cyc;
  logic [31:0] last_res;
  bit          last_err;
  int          n_start;
  int          exp_order [8] = '{0, 1, 2, 3, 0, 2, 0, 2};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[IW'((last + k) % NR)]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  task automatic rnd_ops(input int i);
    op1[IW'(i)] = $urandom;
    op2[IW'(i)] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    opc[IW'(i)] = 2'($urandom_range(0, 3));
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  // and the coprocessor stand-in.
  task automatic cycle();
    int            w;
    int            lim;
    logic [NR-1:0] e_rdy;
    logic [NR-1:0] e_rv;
    bit            due;
    bit            acc;
    bit            hs;
    bit            e_start;
    #2;
    w     = op_open ? -1 : rr_pick(req_valid, mdl_last);
    e_rdy = (w >= 0) ? (NR'(1) << w) : '0;
    check_val("req_ready", 64'(req_ready), 64'(e_rdy));
    check_val("busy", 64'(busy), 64'(op_open));
    e_start = op_open && (cyc == t_acc + 1);
    check_val("cp_start", 64'(cp_start), 64'(e_start));
    if (cp_start) n_start++;
    if (e_start) begin
      check_val("cp_num1", 64'(cp_num1), 64'(acc_op1));
      check_val("cp_num2", 64'(cp_num2), 64'(acc_op2));
      check_val("cp_instr", 64'(cp_instruction), 64'(acc_opc));
    end
    lim  = (lat_cur == 0 || lat_cur > TO) ? TO : lat_cur;
    due  = op_open && (cyc >= t_acc + 2 + lim);
    e_rv = due ? (NR'(1) << exp_g) : '0;
    check_val("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    if (due) begin
      check_val("rsp_result", 64'(rsp_result), 64'(exp_res));
      check_val("rsp_error", 64'(rsp_error), 64'(exp_err));
    end
    if (op_open) check_val("grant_id", 64'(grant_id), 64'(exp_g));
    acc = (w >= 0);
    hs  = due && rsp_ready[IW'(exp_g)];
    if (hs) begin
      last_res = rsp_result;
      last_err = rsp_error;
    end
    if (cp_start && lat_cur > 0) pulse_at = cyc + lat_cur;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      op_open   = 1'b0;
      mdl_last  = exp_g;
      done_flag = 1'b1;
      hs_cyc    = cyc - 1;
    end
    if (acc) begin
      op_open  = 1'b1;
      exp_g    = w;
      t_acc    = cyc - 1;
      acc_op1  = op1[IW'(w)];
      acc_op2  = op2[IW'(w)];
      acc_opc  = opc[IW'(w)];
      lat_cur  = cfg_lat;
      exp_err  = (cfg_lat == 0) || (cfg_lat > TO);
      exp_res  = exp_err ? 32'd0 : alu(acc_opc, acc_op1, acc_op2);
      grant_log.push_back(w);
      acc_flag = 1'b1;
      if (!hold[w]) req_valid[IW'(w)] = 1'b0;
      rnd_ops(w);
    end
    cp_ready  = (pulse_at == cyc) || (acc && spur_issue);
    cp_result = (pulse_at == cyc) ? alu(cp_instruction, cp_num1, cp_num2) : $urandom;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_acc(input int budget);
    acc_flag = 1'b0;
    for (int i = 0; i < budget && !acc_flag; i++) cycle();
    check_val("grant_within_budget", 64'(acc_flag), 64'd1);
  endtask

  task automatic run_done(input int budget);
    done_flag = 1'b0;
    for (int i = 0; i < budget && !done_flag; i++) cycle();
    check_val("response_within_budget", 64'(done_flag), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_error, cp_start, busy, grant_id, cp_instruction}), 64'd0);
    check_val({tag, "_res"}, 64'(rsp_result), 64'd0);
    check_val({tag, "_num"}, {cp_num1, cp_num2}, 64'd0);
  endtask

  task automatic model_reset();
    mdl_last   = NR - 1;
    op_open    = 1'b0;
    pulse_at   = -1;
    lat_cur    = 0;
    t_acc      = -10;
    cp_ready   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [31:0] want;
    reset_n    = 1'b0;
    req_valid  = '0;
    rsp_ready  = '1;
    cp_result  = '0;
    spur_issue = 1'b0;
    cfg_lat    = 1;
    n_start    = 0;
    for (int i = 0; i < NR; i++) begin
      rnd_ops(i);
      hold[i] = 1'b0;
    end
    model_reset();

    // Reset values
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Round-robin with all requesters held, then only 0 and 2
    for (int i = 0; i < NR; i++) hold[i] = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      cfg_lat = $urandom_range(1, 4);
      run_acc(60);
    end
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_lat = $urandom_range(1, 4);
      run_acc(60);
    end
    req_valid = '0;
    for (int i = 0; i < NR; i++) hold[i] = 1'b0;
    run_done(60);
    check_val("rr_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      check_val("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));
    end

    // Single ADD request with a 3-cycle coprocessor
    op1[0] = 32'd7;
    op2[0] = 32'd5;
    opc[0] = OP_ADD;
    cfg_lat = 3;
    req_valid[0] = 1'b1;
    n_start = 0;
    run_acc(5);
    a = t_acc;
    run_done(40);
    check_val("single_grant", 64'(grant_log[$]), 64'd0);
    check_val("single_result", 64'(last_res), 64'd12);
    check_val("single_error", 64'(last_err), 64'd0);
    check_val("single_latency", 64'(hs_cyc - a), 64'd5);
    check_val("single_start_pulses", 64'(n_start), 64'd1);

    // Timeout, then a normal request
    cfg_lat = 0;
    req_valid[2] = 1'b1;
    run_acc(10);
    a = t_acc;
    run_done(TO + 20);
    check_val("timeout_error", 64'(last_err), 64'd1);
    check_val("timeout_result", 64'(last_res), 64'd0);
    check_val("timeout_latency", 64'(hs_cyc - a), 64'(TO + 2));
    cfg_lat = 2;
    want = alu(opc[2], op1[2], op2[2]);
    req_valid[2] = 1'b1;
    run_acc(10);
    run_done(20);
    check_val("after_timeout_error", 64'(last_err), 64'd0);
    check_val("after_timeout_result", 64'(last_res), 64'(want));

    // Response backpressure with another requester waiting
    rsp_ready = 4'b1101;
    cfg_lat = 2;
    req_valid[1] = 1'b1;
    run_acc(10);
    req_valid[3] = 1'b1;
    run_n(3);
    run_n(10);
    check_val("bp_rsp_held", 64'(rsp_valid), 64'h2);
    check_val("bp_req3_blocked", 64'(req_ready), 64'd0);
    rsp_ready = '1;
    run_done(5);
    a = hs_cyc;
    run_acc(5);
    check_val("bp_next_grant", 64'(grant_log[$]), 64'd3);
    check_val("bp_grant_gap", 64'(t_acc - a), 64'd1);
    run_done(20);

    // Spurious cp_ready in IDLE and in the ISSUE cycle
    run_n(2);
    cp_ready = 1'b1;
    cycle();
    cp_ready = 1'b1;
    cycle();
    spur_issue = 1'b1;
    cfg_lat = 3;
    want = alu(opc[0], op1[0], op2[0]);
    req_valid[0] = 1'b1;
    run_acc(5);
    spur_issue = 1'b0;
    run_done(20);
    check_val("spur_result", 64'(last_res), 64'(want));
    check_val("spur_error", 64'(last_err), 64'd0);

    // Reset while waiting on the coprocessor
    cfg_lat = 0;
    req_valid[1] = 1'b1;
    run_acc(10);
    run_n(4);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    cfg_lat = 1;
    req_valid = 4'b0101;
    run_acc(5);
    check_val("post_reset_grant", 64'(grant_log[$]), 64'd0);
    run_done(20);
    run_acc(10);
    run_done(20);
    run_n(5);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      int r;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[IW'(i)] && $urandom_range(0, 3) == 0) req_valid[IW'(i)] = 1'b1;
        else if (req_valid[IW'(i)] && $urandom_range(0, 15) == 0) req_valid[IW'(i)] = 1'b0;
      end
      rsp_ready = NR'($urandom);
      r = $urandom_range(0, 9);
      cfg_lat = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO : $urandom_range(1, 6);
      cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    run_n(TO + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
